uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int W            = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [W-1:0] CNT_FULL = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] CNT_HALF = W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic [2:0]   idx;
    logic [7:0]   shreg;
    logic         rx_m;
    logic         rx_s;
    logic         accept;

    assign accept = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == PARITY && cnt == CNT_FULL)
                par_bad <= (^shreg) ^ rx_s;
            // Reported with the delivery or the overrun of the same frame.
            if (state == STOP && cnt == CNT_FULL && rx_s)
                parity_err <= par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (accept) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Line held low: wait for idle before looking for a start bit.
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    int vrise = 0, vhigh = 0, fe_n = 0, ov_n = 0, pe_n = 0, pe_rise = 0;
    int rise_cyc = 0;
    logic [7:0] vdata = 8'h00;
    logic valid_q = 1'b0;

    int s_vr, s_vh, s_fe, s_ov, s_pe, s_pr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            vrise = vrise + 1;
            vdata = data;
            rise_cyc = cyc;
            if (parity_err) pe_rise = pe_rise + 1;
        end
        if (valid) vhigh = vhigh + 1;
        if (frame_err) fe_n = fe_n + 1;
        if (overrun) ov_n = ov_n + 1;
        if (parity_err) pe_n = pe_n + 1;
        valid_q = valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_vr = vrise; s_vh = vhigh; s_fe = fe_n;
        s_ov = ov_n;  s_pe = pe_n;  s_pr = pe_rise;
    endtask

    // Leaves rx at the stop-bit level when it returns.
    task automatic send(input logic [7:0] b, input logic stop_b,
                        input logic par_flip);
        rx = 1'b0;
        t0 = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_b;
        tick(CPB);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        chk("rst_pe", parity_err, 1'b0);

        // Basic byte with ready high
        ready = 1'b1;
        snap();
        send(8'hA5, 1'b1, 1'b0);
        tick(4);
        chk("a5_rise", vrise - s_vr, 1);
        chk("a5_high", vhigh - s_vh, 1);
        chk("a5_data", vdata, 8'hA5);
        chk("a5_lat", (rise_cyc - t0 >= LAT - 1) && (rise_cyc - t0 <= LAT + 1), 1);
        chk("a5_fe", fe_n - s_fe, 0);
        chk("a5_ov", ov_n - s_ov, 0);
        chk("a5_pe", pe_n - s_pe, 0);

        // Glitch then a real frame
        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        chk("gl_rise", vrise - s_vr, 0);
        chk("gl_fe", fe_n - s_fe, 0);
        send(8'h3C, 1'b1, 1'b0);
        tick(4);
        chk("3c_rise", vrise - s_vr, 1);
        chk("3c_data", vdata, 8'h3C);

        // Framing error then held-low break
        snap();
        send(8'h55, 1'b0, 1'b0);
        tick(40);
        chk("fe_pulse", fe_n - s_fe, 1);
        chk("fe_novalid", vrise - s_vr, 0);
        chk("fe_valid", valid, 1'b0);
        rx = 1'b1;
        tick(6);
        chk("brk_rise", vrise - s_vr, 0);
        send(8'h81, 1'b1, 1'b0);
        tick(4);
        chk("81_rise", vrise - s_vr, 1);
        chk("81_data", vdata, 8'h81);
        chk("81_fe", fe_n - s_fe, 1);

        // Overrun with ready low
        ready = 1'b0;
        snap();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        tick(4);
        chk("ov_valid", valid, 1'b1);
        chk("ov_data", data, 8'h11);
        chk("ov_pulse", ov_n - s_ov, 1);
        chk("ov_rise", vrise - s_vr, 1);
        chk("ov_fe", fe_n - s_fe, 0);
        ready = 1'b1;
        tick(1);
        chk("ov_clr", valid, 1'b0);
        chk("ov_hold", data, 8'h11);

        // Asynchronous reset in the middle of bit 3 of 0xF8
        snap();
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", data, 8'h00);
        chk("arst_valid", valid, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(CPB * 7);
        chk("arst_rise", vrise - s_vr, 0);
        chk("arst_fe", fe_n - s_fe, 0);
        send(8'hF0, 1'b1, 1'b0);
        tick(4);
        chk("f0_rise", vrise - s_vr, 1);
        chk("f0_data", vdata, 8'hF0);

`ifdef UART_RX_PARITY_EN
        snap();
        send(8'h07, 1'b1, 1'b1);
        tick(4);
        chk("pbad_rise", vrise - s_vr, 1);
        chk("pbad_data", vdata, 8'h07);
        chk("pbad_pe", pe_n - s_pe, 1);
        chk("pbad_coin", pe_rise - s_pr, 1);
        snap();
        send(8'h07, 1'b1, 1'b0);
        tick(4);
        chk("pok_rise", vrise - s_vr, 1);
        chk("pok_pe", pe_n - s_pe, 0);
`else
        chk("nopar_pe", pe_n, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
